shift_unit: RTL
===============

# shift_unit

Parametrised, multi-cycle successor to the combinational operand shifter in the execute stage. It accepts one shifter-operand request per valid/ready handshake and computes the ARM addressing-mode-1/2 operand and shifter carry-out. The iterative datapath moves at most STEP bit positions per cycle. It sits between register-file read and the ALU, and stalls issue through `in_ready`.

## Interface
- `N`, 32, datapath width; power of two, ≥8.
- `STEP`, 4, maximum bit positions shifted per BUSY cycle; power of two, 1..N.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: unit can accept; high only in IDLE.
- `rm_in` in N: operand Rm.
- `rs_in` in 8: register shift amount (Rs[7:0]).
- `shift_in` in 12: instruction bits [11:0].
- `type_in` in 3: 000 imm shift, 001 imm rotate, 010 LS imm offset, 011 LS reg offset, 100 reg shift.
- `carry_in` in 1: current CPSR C.
- `out_valid` out 1: result valid; held until accepted.
- `out_ready` in 1: consumer accepts.
- `shifter_out` out N: operand result.
- `shifter_carry_out` out 1: shifter carry.

## Operation
- Request fields are captured on the accept edge (`in_valid && in_ready`). Later input changes are ignored.
- FSM states and transitions:
  - IDLE → BUSY when the accepted request has effective amount k>0.
  - IDLE → DONE when the request is a direct case.
  - BUSY → DONE when the remaining count reaches 0.
  - DONE → IDLE on `out_ready`.
- Effective amounts:
  - 000: amount = `shift_in[11:7]` (log2 N bits); op = `shift_in[6:5]`.
  - 100: amount = `rs_in`; op = `shift_in[6:5]`.
  - 001: amount = 2·`shift_in[11:8]` mod N; operand = zero-extended `shift_in[7:0]`; op = ROR.
- Direct cases (result formed in one cycle, no BUSY):
  - 010: out = zero-extended `shift_in`; C = `carry_in`.
  - 011: out = `rm_in`; C = `carry_in`.
  - Any op with amount 0 and no special encoding: out = operand; C = `carry_in`.
  - Imm LSR #0 means LSR #N: out = 0; C = Rm[N-1].
  - Imm ASR #0 means ASR #N: out = {N{Rm[N-1]}}; C = Rm[N-1].
  - Imm ROR #0 means RRX: out = {`carry_in`, Rm[N-1:1]}; C = Rm[0].
  - Reg LSL/LSR = N: out = 0; C = Rm[0] (LSL) / Rm[N-1] (LSR).
  - Reg LSL/LSR > N: out = 0; C = 0.
  - Reg ASR ≥ N: out = sign fill; C = Rm[N-1].
  - Reg ROR: amount taken mod N. If nonzero, iterate. If the amount is a nonzero multiple of N, out = Rm and C = Rm[N-1].
- Iterative shift:
  - Each BUSY cycle shifts by min(STEP, remaining).
  - ASR fills with the captured Rm[N-1]; ROR wraps.
  - C = last bit shifted out. For rotates this equals final out[N-1].
  - Imm rotate with rot=0 gives C = `carry_in`.
- Undefined `type_in` (101–111): treated as 011.

## Timing
- Reset values: `in_ready`=0 while `rst` high, 1 from the first cycle after; `out_valid`=0; `shifter_out`=0; `shifter_carry_out`=0; FSM=IDLE; counter=0.
- Latency from accept edge to `out_valid` high = 1 + ceil(k/STEP) cycles, where k is the iterated amount. Direct cases take 1 cycle.
- Throughput: one result per (latency + 1) cycles when `out_ready` is held high. No overlap: `in_ready` is low in BUSY and DONE.
- DONE holds `shifter_out` and `shifter_carry_out` stable until the `out_valid && out_ready` edge.
- `rst` in any state: next state is IDLE, the in-flight request is discarded, and the next cycle shows reset values.

## Configuration
- `SHIFT_UNIT_REGSHIFT_EN` defined: type 100 (register-specified shift) behaves as described above.
- Undefined: type 100 is treated as 011, and `rs_in` is unused (tied off internally).

## Structure
- Package `shift_unit_pkg` holds:
  - `type_in` codes as an enum: IMM_SHIFT, IMM_ROT, LS_IMM, LS_REG, REG_SHIFT.
  - Shift-op enum: LSL, LSR, ASR, ROR.
  - FSM state enum: IDLE, BUSY, DONE.
- Sub-module `shift_step`: a combinational single-iteration slice.
  - Inputs: value, op, amount ≤ STEP, fill bit.
  - Outputs: shifted value and last-out bit.
  - Instantiated once in the BUSY datapath.

## Test plan
- Imm LSL: Rm=0x8000_0001, amount 1, STEP=4 → out 0x0000_0002, C=1, `out_valid` 2 cycles after accept.
- Imm ASR #0: Rm=0x8000_0000 → out 0xFFFF_FFFF, C=1, 1 cycle.
- Imm rotate: `shift_in`=0x4FF (0xFF ror 8) → out 0xFF00_0000, C=1, 1+ceil(8/4)=3 cycles.
- RRX: Rm=0x0000_0003, `carry_in`=1 → out 0x8000_0001, C=1.
- Reg LSR:
  - Rs=32, Rm=0x8000_0000 → out 0, C=1.
  - Rs=33 → out 0, C=0.
  - With the macro undefined, the same request returns out=Rm, C=`carry_in`.
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles in DONE → outputs stable and `in_ready`=0 throughout.
  - Assert `rst` mid-BUSY → next cycle `out_valid`=0, outputs 0, and the unit accepts a new request after reset.

Source files
------------

// File: rtl/shift_unit_pkg.sv
// rtl/shift_unit_pkg.sv - request type, shift op and FSM state encodings for shift_unit
package shift_unit_pkg;

  typedef enum logic [2:0] {
    IMM_SHIFT = 3'b000,
    IMM_ROT   = 3'b001,
    LS_IMM    = 3'b010,
    LS_REG    = 3'b011,
    REG_SHIFT = 3'b100
  } req_type_e;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one BUSY-cycle slice: shifts value by up to STEP positions
module shift_step
  import shift_unit_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 4,
  parameter int SAW  = $clog2(STEP) + 1
) (
  input  logic [N-1:0]   value,
  input  shift_op_e      op,
  input  logic [SAW-1:0] amount,
  input  logic           fill,
  output logic [N-1:0]   result,
  output logic           last_out
);

  logic [N-1:0] v;
  logic         lo;

  // Unrolled into STEP single-bit stages; stages beyond amount pass through.
  always_comb begin
    v  = value;
    lo = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(amount)) begin
        case (op)
          LSL:     begin lo = v[N-1]; v = {v[N-2:0], 1'b0}; end
          LSR:     begin lo = v[0];   v = {1'b0, v[N-1:1]}; end
          ASR:     begin lo = v[0];   v = {fill, v[N-1:1]}; end
          default: begin lo = v[0];   v = {v[0], v[N-1:1]}; end
        endcase
      end
    end
    result   = v;
    last_out = lo;
  end

endmodule

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - iterative ARM shifter-operand unit with valid/ready handshakes
// Optional SHIFT_UNIT_REGSHIFT_EN: enables register-specified shifts (type 100).
module shift_unit
  import shift_unit_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] rm_in,
  input  logic [7:0]   rs_in,
  input  logic [11:0]  shift_in,
  input  logic [2:0]   type_in,
  input  logic         carry_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] shifter_out,
  output logic         shifter_carry_out
);

  localparam int LOGN = $clog2(N);
  localparam int SAW  = $clog2(STEP) + 1;
  localparam int unsigned N_U    = N;
  localparam int unsigned STEP_U = STEP;

  state_e          state, state_next;
  logic [LOGN-1:0] cnt;
  logic [N-1:0]    val;
  shift_op_e       op_q;
  logic            fill_q, c_q;

  req_type_e       ty;
  shift_op_e       d_op;
  logic            d_direct, d_c;
  logic [N-1:0]    d_val;
  logic [LOGN-1:0] d_k;
  logic [7:0]      rs_amt;
  int unsigned     amt;

  logic            accept;
  int unsigned     rem_step;
  logic [SAW-1:0]  step_amt;
  logic [N-1:0]    step_val;
  logic            step_out;

`ifdef SHIFT_UNIT_REGSHIFT_EN
  assign rs_amt = rs_in;
`else
  logic unused_rs;
  assign unused_rs = ^rs_in;
  assign rs_amt    = 8'd0;
`endif

  assign in_ready          = (state == IDLE) && !rst;
  assign accept            = in_valid && in_ready;
  assign out_valid         = (state == DONE);
  assign shifter_out       = val;
  assign shifter_carry_out = c_q;

  // Request decode: either a finished result (direct) or an operand plus iteration count.
  always_comb begin
    ty = req_type_e'(type_in);
    if (type_in > 3'b100) ty = LS_REG;
`ifndef SHIFT_UNIT_REGSHIFT_EN
    if (ty == REG_SHIFT) ty = LS_REG;
`endif
    d_op     = shift_op_e'(shift_in[6:5]);
    d_val    = rm_in;
    d_c      = carry_in;
    d_direct = 1'b1;
    amt      = 0;
    case (ty)
      LS_IMM: d_val = N'(shift_in);
      IMM_ROT: begin
        d_op     = ROR;
        d_val    = N'(shift_in[7:0]);
        amt      = (32'(shift_in[11:8]) * 2) % N_U;
        d_direct = (amt == 0);
      end
      IMM_SHIFT: begin
        amt      = 32'(shift_in[11:7]) % N_U;
        d_direct = (amt == 0);
        if (amt == 0) begin
          case (d_op)
            LSR:     begin d_val = '0;               d_c = rm_in[N-1]; end
            ASR:     begin d_val = {N{rm_in[N-1]}};  d_c = rm_in[N-1]; end
            ROR:     begin d_val = {carry_in, rm_in[N-1:1]}; d_c = rm_in[0]; end
            default: ;
          endcase
        end
      end
      REG_SHIFT: begin
        amt = 32'(rs_amt);
        if (d_op == ROR) begin
          if (amt != 0 && amt % N_U == 0) d_c = rm_in[N-1];
          amt = amt % N_U;
        end else if (amt >= N_U) begin
          d_val = (d_op == ASR) ? {N{rm_in[N-1]}} : '0;
          if (d_op == ASR || (d_op == LSR && amt == N_U)) d_c = rm_in[N-1];
          else if (d_op == LSL && amt == N_U)             d_c = rm_in[0];
          else                                            d_c = 1'b0;
          amt = 0;
        end
        d_direct = (amt == 0);
      end
      default: ;
    endcase
    d_k = LOGN'(amt);
  end

  always_comb begin
    rem_step = (32'(cnt) > STEP_U) ? STEP_U : 32'(cnt);
    step_amt = SAW'(rem_step);
  end

  shift_step #(.N(N), .STEP(STEP), .SAW(SAW)) u_step (
    .value    (val),
    .op       (op_q),
    .amount   (step_amt),
    .fill     (fill_q),
    .result   (step_val),
    .last_out (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = d_direct ? DONE : BUSY;
      BUSY:    if (32'(cnt) <= STEP_U) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      val    <= '0;
      c_q    <= 1'b0;
      op_q   <= LSL;
      fill_q <= 1'b0;
    end else if (accept) begin
      cnt    <= d_direct ? '0 : d_k;
      val    <= d_val;
      c_q    <= d_c;
      op_q   <= d_op;
      fill_q <= rm_in[N-1];
    end else if (state == BUSY) begin
      cnt <= cnt - LOGN'(rem_step);
      val <= step_val;
      c_q <= step_out;
    end
  end

endmodule
